// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared types and helpers for the instruction fetch stage:
//            FSM state encoding and instruction field extraction.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,  // no request outstanding
        FETCH_REQ  = 2'd1,  // request outstanding, response will be kept
        FETCH_DROP = 2'd2   // request outstanding, response will be discarded
    } fetch_state_e;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_HI:OPCODE_LO];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] word);
        return word[FUNCT_HI:FUNCT_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory request/response and decode handshake
//            signals of the fetch stage, plus the redirect input.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_data;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [5:0]      if_opcode;
    logic [5:0]      if_funct;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode, if_funct,
        input  imem_ack, imem_data, redirect_en, redirect_pc, if_ready
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode, if_funct,
        output imem_ack, imem_data, redirect_en, redirect_pc, if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO holding {instruction, pc} pairs between
//            instruction memory and decode. Flush overrides push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire logic                   pop_i,
    input  wire logic                   flush_i,
    input  wire logic [WIDTH-1:0]       wdata_i,
    output logic      [WIDTH-1:0]       rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic      [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the fetch PC, keeps at most one
//            request outstanding to instruction memory, buffers returned
//            words and hands them to decode; redirects flush wrong-path work.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              req_w;
    logic              push_w;
    logic              pop_w;
    logic              full_w;
    logic              empty_w;
    logic [CW-1:0]     count_w;
    logic [CW-1:0]     count_after_w;
    logic [2*XLEN-1:0] head_w;
    logic [XLEN-1:0]   head_instr_w;
    logic [XLEN-1:0]   head_pc_w;
    logic [XLEN-1:0]   redir_pc_w;
    logic [XLEN-1:0]   pc_inc_w;

    assign redir_pc_w    = bus.redirect_pc & ~XLEN'(3);
    assign pc_inc_w      = pc_q + XLEN'(4);
    assign pop_w         = bus.if_valid && bus.if_ready && !bus.redirect_en;
    // Occupancy after a push this cycle, used to decide whether to keep fetching
    assign count_after_w = count_w + CW'(1) - CW'(pop_w);

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push_w),
        .pop_i   (pop_w),
        .flush_i (bus.redirect_en),
        .wdata_i ({bus.imem_data, req_addr_q}),
        .rdata_o (head_w),
        .full_o  (full_w),
        .empty_o (empty_w),
        .count_o (count_w)
    );

    // State, PC and in-flight address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state logic; a redirect outranks every other event
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_w      = 1'b0;
        push_w     = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (bus.redirect_en) begin
                    pc_d       = redir_pc_w;
                    req_addr_d = redir_pc_w;
                    state_d    = FETCH_REQ;
                end else if (!full_w) begin
                    req_addr_d = pc_q;
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                req_w = 1'b1;
                if (bus.redirect_en) begin
                    pc_d = redir_pc_w;
                    if (bus.imem_ack) begin
                        req_addr_d = redir_pc_w;
                        state_d    = FETCH_REQ;
                    end else begin
                        state_d = FETCH_DROP;
                    end
                end else if (bus.imem_ack) begin
                    push_w     = 1'b1;
                    pc_d       = pc_inc_w;
                    req_addr_d = pc_inc_w;
                    state_d    = (count_after_w < CW'(FIFO_DEPTH)) ? FETCH_REQ : FETCH_IDLE;
                end
            end
            FETCH_DROP: begin
                // Old request stays on the bus until its response is swallowed
                req_w = 1'b1;
                if (bus.redirect_en) pc_d = redir_pc_w;
                if (bus.imem_ack) begin
                    req_addr_d = bus.redirect_en ? redir_pc_w : pc_q;
                    state_d    = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the first edge
    assign head_instr_w  = reset ? '0 : head_w[2*XLEN-1:XLEN];
    assign head_pc_w     = reset ? '0 : head_w[XLEN-1:0];
    assign bus.imem_req  = req_w && !reset;
    assign bus.imem_addr = reset ? RESET_PC : req_addr_q;
    assign bus.if_valid  = !empty_w && !reset;
    assign bus.if_instr  = head_instr_w;
    assign bus.if_pc     = head_pc_w;
    assign bus.if_opcode = opcode_of(head_instr_w[31:0]);
    assign bus.if_funct  = funct_of(head_instr_w[31:0]);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit: vector table for
//            streaming, back-pressure, wrap and redirect cases, plus
//            hand-written sequences for slow acks and reset during DROP.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    logic zero_wait;
    logic man_ack;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory model: two real instructions, a scrambled address elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h012A_4020;
            32'h0000_0104: return 32'h8D09_0004;
            default:       return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.imem_ack  = zero_wait ? bus.imem_req : man_ack;
    assign bus.imem_data = mem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks outputs of the current cycle against expectations
    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
        logic [31:0] w;
        chk({tag, " imem_req"}, {31'b0, bus.imem_req}, {31'b0, req});
        if (req) chk({tag, " imem_addr"}, bus.imem_addr, addr);
        chk({tag, " if_valid"}, {31'b0, bus.if_valid}, {31'b0, valid});
        if (valid) begin
            w = mem_word(pc);
            chk({tag, " if_pc"}, bus.if_pc, pc);
            chk({tag, " if_instr"}, bus.if_instr, w);
            chk({tag, " if_opcode"}, {26'b0, bus.if_opcode}, {26'b0, w[31:26]});
            chk({tag, " if_funct"}, {26'b0, bus.if_funct}, {26'b0, w[5:0]});
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        dec;
        logic [5:0]  op;
        logic [5:0]  fn;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    initial begin
        //          rst  rdy  red  rpc           req  addr          vld  pc            dec  op     fn
        vecs[0]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[1]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[4]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0,        1'b0,6'h00,6'h00};
        vecs[5]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h4,        1'b0,6'h00,6'h00};
        vecs[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'h8,        1'b0,6'h00,6'h00};
        // Reset while a request is live, then stall decode
        vecs[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0,        1'b0,6'h00,6'h00};
        vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,6'h00,6'h00};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,6'h00,6'h00};
        vecs[13] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,6'h00,6'h00};
        vecs[14] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h4,        1'b0,6'h00,6'h00};
        vecs[15] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h8,        1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[16] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'h8,        1'b0,6'h00,6'h00};
        // Redirect near the top of the address space: PC wraps to zero
        vecs[17] = '{1'b0,1'b1,1'b1,32'hFFFF_FFF8,1'b1,32'h10,       1'b1,32'hC,        1'b0,6'h00,6'h00};
        vecs[18] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hFFFF_FFF8,1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[19] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b1,32'hFFFF_FFF8,1'b0,6'h00,6'h00};
        vecs[20] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,6'h00,6'h00};
        vecs[21] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0,        1'b0,6'h00,6'h00};
        // Redirect coinciding with ack and a decode transfer; low bits ignored
        vecs[22] = '{1'b0,1'b1,1'b1,32'h43,       1'b1,32'h8,        1'b1,32'h4,        1'b0,6'h00,6'h00};
        vecs[23] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h40,       1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[24] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h44,       1'b1,32'h40,       1'b0,6'h00,6'h00};
        // Real instructions: add and lw field decode
        vecs[25] = '{1'b0,1'b1,1'b1,32'h100,      1'b1,32'h48,       1'b1,32'h44,       1'b0,6'h00,6'h00};
        vecs[26] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h100,      1'b0,32'h0,        1'b0,6'h00,6'h00};
        vecs[27] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h104,      1'b1,32'h100,      1'b1,6'h00,6'h20};
        vecs[28] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h108,      1'b1,32'h104,      1'b1,6'h23,6'h04};

        reset           = 1'b1;
        zero_wait       = 1'b1;
        man_ack         = 1'b0;
        bus.if_ready    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        tick();

        // Table-driven section: inputs applied, outputs of that same cycle checked
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            reset           = vecs[i].rst;
            bus.if_ready    = vecs[i].ready;
            bus.redirect_en = vecs[i].redir;
            bus.redirect_pc = vecs[i].rpc;
            #1;
            expect_out(tag, vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc);
            if (vecs[i].rst) begin
                chk({tag, " rst imem_addr"}, bus.imem_addr, 32'h0);
                chk({tag, " rst if_pc"}, bus.if_pc, 32'h0);
                chk({tag, " rst if_instr"}, bus.if_instr, 32'h0);
                chk({tag, " rst if_opcode"}, {26'b0, bus.if_opcode}, 32'h0);
            end
            if (vecs[i].dec) begin
                chk({tag, " dec opcode"}, {26'b0, bus.if_opcode}, {26'b0, vecs[i].op});
                chk({tag, " dec funct"}, {26'b0, bus.if_funct}, {26'b0, vecs[i].fn});
            end
            tick();
        end

        // Slow memory: redirect to 0x40 while the request to 0x8 waits for its ack
        bus.redirect_en = 1'b0;
        reset = 1'b1; zero_wait = 1'b1; bus.if_ready = 1'b1;
        tick();
        reset = 1'b0; #1; expect_out("s0", 1'b0, 32'h0, 1'b0, 32'h0); tick();
        #1; expect_out("s1", 1'b1, 32'h0, 1'b0, 32'h0); tick();
        #1; expect_out("s2", 1'b1, 32'h4, 1'b1, 32'h0); tick();
        zero_wait = 1'b0; bus.redirect_en = 1'b1; bus.redirect_pc = 32'h40;
        #1; expect_out("s3", 1'b1, 32'h8, 1'b1, 32'h4); tick();
        bus.redirect_en = 1'b0;
        #1; expect_out("s4 drop", 1'b1, 32'h8, 1'b0, 32'h0); tick();
        man_ack = 1'b1;
        #1; expect_out("s5 drop ack", 1'b1, 32'h8, 1'b0, 32'h0); tick();
        man_ack = 1'b0; zero_wait = 1'b1;
        #1; expect_out("s6 newpc", 1'b1, 32'h40, 1'b0, 32'h0); tick();

        // Enter DROP again, then reset with a late ack right after it
        zero_wait = 1'b0; bus.redirect_en = 1'b1; bus.redirect_pc = 32'h80;
        #1; expect_out("s7", 1'b1, 32'h44, 1'b1, 32'h40); tick();
        bus.redirect_en = 1'b0;
        #1; expect_out("s8 drop", 1'b1, 32'h44, 1'b0, 32'h0);
        reset = 1'b1;
        #1; chk("s8 rst imem_req", {31'b0, bus.imem_req}, 32'h0);
        chk("s8 rst imem_addr", bus.imem_addr, 32'h0);
        tick();
        reset = 1'b0; man_ack = 1'b1;
        #1; expect_out("s9 late ack", 1'b0, 32'h0, 1'b0, 32'h0); tick();
        man_ack = 1'b0;
        #1; expect_out("s10", 1'b1, 32'h0, 1'b0, 32'h0); tick();
        man_ack = 1'b1;
        #1; expect_out("s11", 1'b1, 32'h0, 1'b0, 32'h0); tick();
        man_ack = 1'b0;
        #1; expect_out("s12", 1'b1, 32'h4, 1'b1, 32'h0); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
